// File: rtl/cred_scroll_ctrl_if.sv
// Control and output bundle between the credits sequencer and the char-drawing stage.
// The slave side is the sequencer; the master side drives frame timing and handshakes.
interface cred_scroll_ctrl_if;
    logic        vblnk_in;
    logic        start;
    logic        abort;
    logic        pause;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [11:0] color1;
    logic [11:0] color2;
    logic        busy;
    logic        done;

    modport master (
        output vblnk_in, start, abort, pause,
        input  xpos, ypos, color1, color2, busy, done
    );

    modport slave (
        input  vblnk_in, start, abort, pause,
        output xpos, ypos, color1, color2, busy, done
    );
endinterface

// File: rtl/cred_scroll_ctrl.sv
// Credits sequencer: once per frame scrolls the text block up, holds it,
// fades the text colour into the background, then pulses done.
module cred_scroll_ctrl #(
    parameter int          SCREEN_H    = 600,
    parameter int          X_POS       = 272,
    parameter int          Y_STOP      = 284,
    parameter int          SCROLL_STEP = 2,
    parameter int          HOLD_FRAMES = 120,
    parameter int          FADE_DIV    = 4,
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    cred_scroll_ctrl_if.slave    bus
);

    localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
    localparam int DIV_EFF  = (FADE_DIV < 1) ? 1 : FADE_DIV;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCROLL,
        S_HOLD,
        S_FADE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_vblnk_q;
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic [11:0] r_color1;
    logic [11:0] r_color2;
    logic [15:0] r_hold_cnt;
    logic [7:0]  r_div_cnt;
    logic        r_busy;
    logic        r_done;

    logic [11:0] w_ypos_nxt;
    logic [11:0] w_color2_nxt;
    logic [15:0] w_hold_nxt;
    logic [7:0]  w_div_nxt;
    logic        w_tick;
    logic [12:0] w_ysub;
    logic        w_scroll_end;
    logic [15:0] w_hold_inc;
    logic [7:0]  w_div_inc;
    logic [11:0] w_color_step;

    // Each 4-bit channel moves one LSB toward the target; equal channels hold.
    function automatic logic [11:0] fade_step(input logic [11:0] cur, input logic [11:0] tgt);
        logic [11:0] res;
        res = cur;
        for (int c = 0; c < 3; c++) begin
            if (cur[c*4 +: 4] > tgt[c*4 +: 4])
                res[c*4 +: 4] = cur[c*4 +: 4] - 4'd1;
            else if (cur[c*4 +: 4] < tgt[c*4 +: 4])
                res[c*4 +: 4] = cur[c*4 +: 4] + 4'd1;
        end
        return res;
    endfunction

    // Ticks seen while paused are dropped, not deferred: vblnk history still advances.
    assign w_tick       = bus.vblnk_in & ~r_vblnk_q & ~bus.pause;
    assign w_ysub       = {1'b0, r_ypos} - 13'(SCROLL_STEP);
    assign w_scroll_end = ({1'b0, r_ypos} < 13'(SCROLL_STEP)) || (w_ysub <= 13'(Y_STOP));
    assign w_hold_inc   = r_hold_cnt + 16'd1;
    assign w_div_inc    = r_div_cnt + 8'd1;
    assign w_color_step = fade_step(r_color2, r_color1);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ypos_nxt   = r_ypos;
        w_color2_nxt = r_color2;
        w_hold_nxt   = r_hold_cnt;
        w_div_nxt    = r_div_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_SCROLL;
            end
            S_SCROLL: begin
                if (w_tick) begin
                    if (w_scroll_end) begin
                        w_ypos_nxt  = 12'(Y_STOP);
                        w_hold_nxt  = 16'd0;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_ypos_nxt  = w_ysub[11:0];
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == 16'(HOLD_EFF)) begin
                        w_div_nxt   = 8'd0;
                        w_state_nxt = S_FADE;
                    end
                end
            end
            S_FADE: begin
                if (w_tick) begin
                    if (w_div_inc == 8'(DIV_EFF)) begin
                        w_div_nxt    = 8'd0;
                        w_color2_nxt = w_color_step;
                        if (w_color_step == r_color1) w_state_nxt = S_DONE;
                    end else begin
                        w_div_nxt    = w_div_inc;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) w_state_nxt = S_IDLE;
        // IDLE (entered normally or by abort) always carries the rest outputs.
        if (w_state_nxt == S_IDLE) begin
            w_ypos_nxt   = 12'(SCREEN_H);
            w_color2_nxt = FG_COLOR;
            w_hold_nxt   = 16'd0;
            w_div_nxt    = 8'd0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_q  <= 1'b0;
            r_xpos     <= 12'(X_POS);
            r_ypos     <= 12'(SCREEN_H);
            r_color1   <= BG_COLOR;
            r_color2   <= FG_COLOR;
            r_hold_cnt <= 16'd0;
            r_div_cnt  <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_vblnk_q  <= bus.vblnk_in;
            r_xpos     <= 12'(X_POS);
            r_ypos     <= w_ypos_nxt;
            r_color1   <= BG_COLOR;
            r_color2   <= w_color2_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_div_cnt  <= w_div_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.xpos   = r_xpos;
    assign bus.ypos   = r_ypos;
    assign bus.color1 = r_color1;
    assign bus.color2 = r_color2;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_cred_scroll_ctrl.sv
// Directed bench for the credits sequencer: reset, scroll, hold/fade, abort,
// pause and handshake corner cases, with hand-derived expected outputs.
module tb_cred_scroll_ctrl;

    logic pclk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    cred_scroll_ctrl_if bus();

    cred_scroll_ctrl dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    // Counts done-high cycles; sampled just after each active edge.
    always begin
        @(posedge pclk);
        #2;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic do_tick(input int hi);
        @(negedge pclk);
        bus.vblnk_in = 1'b1;
        repeat (hi) @(negedge pclk);
        bus.vblnk_in = 1'b0;
        @(negedge pclk);
    endtask

    task automatic pulse_start();
        @(negedge pclk);
        bus.start = 1'b1;
        @(negedge pclk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.vblnk_in = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        checks++; if ({bus.xpos, bus.ypos} !== {12'd272, 12'd600}) begin errors++; $display("FAIL reset_pos got %0d/%0d exp 272/600", bus.xpos, bus.ypos); end
        checks++; if ({bus.color1, bus.color2, bus.busy, bus.done} !== {12'h000, 12'hFFF, 2'b00}) begin errors++; $display("FAIL reset_ctl got c1=%h c2=%h busy=%b done=%b", bus.color1, bus.color2, bus.busy, bus.done); end
        @(negedge pclk) rst_n = 1'b1;
        pulse_start();
        for (int k = 0; k < 5; k++) do_tick(1);
        checks++; if ({bus.ypos, bus.busy} !== {12'd590, 1'b1}) begin errors++; $display("FAIL midrun_pre got ypos=%0d busy=%b exp 590/1", bus.ypos, bus.busy); end
        @(negedge pclk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.xpos, bus.ypos} !== {12'd272, 12'd600}) begin errors++; $display("FAIL midrun_reset_pos got %0d/%0d exp 272/600", bus.xpos, bus.ypos); end
        checks++; if ({bus.color1, bus.color2, bus.busy, bus.done} !== {12'h000, 12'hFFF, 2'b00}) begin errors++; $display("FAIL midrun_reset_ctl got c1=%h c2=%h busy=%b done=%b", bus.color1, bus.color2, bus.busy, bus.done); end
        @(negedge pclk) rst_n = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_scroll();
        pulse_start();
        checks++; if ({bus.busy, bus.ypos} !== {1'b1, 12'd600}) begin errors++; $display("FAIL scroll_start got busy=%b ypos=%0d exp 1/600", bus.busy, bus.ypos); end
        do_tick(500);
        checks++; if (bus.ypos !== 12'd598) begin errors++; $display("FAIL scroll_long_blank got %0d exp 598", bus.ypos); end
        for (int k = 2; k <= 158; k++) begin
            logic [11:0] exp_y;
            exp_y = 12'(600 - 2*k);
            do_tick(1);
            checks++; if ({bus.ypos, bus.busy} !== {exp_y, 1'b1}) begin errors++; $display("FAIL scroll_ypos tick %0d got %0d busy=%b exp %0d", k, bus.ypos, bus.busy, exp_y); end
        end
    endtask

    task automatic test_hold_fade();
        int base;
        base = done_cnt;
        for (int k = 1; k <= 119; k++) begin
            do_tick(1);
            checks++; if ({bus.ypos, bus.color2} !== {12'd284, 12'hFFF}) begin errors++; $display("FAIL hold tick %0d got ypos=%0d c2=%h exp 284/FFF", k, bus.ypos, bus.color2); end
        end
        do_tick(1);
        for (int k = 1; k <= 59; k++) begin
            logic [3:0]  ch;
            logic [11:0] exp_c;
            ch    = 4'(15 - k/4);
            exp_c = {ch, ch, ch};
            do_tick(1);
            checks++; if ({bus.color2, bus.busy} !== {exp_c, 1'b1}) begin errors++; $display("FAIL fade tick %0d got c2=%h busy=%b exp %h/1", k, bus.color2, bus.busy, exp_c); end
        end
        checks++; if (done_cnt !== base) begin errors++; $display("FAIL fade_early_done got %0d exp %0d", done_cnt, base); end
        @(negedge pclk) bus.vblnk_in = 1'b1;
        @(negedge pclk);
        checks++; if ({bus.done, bus.busy, bus.color2} !== {2'b11, 12'h000}) begin errors++; $display("FAIL done_pulse got done=%b busy=%b c2=%h exp 1/1/000", bus.done, bus.busy, bus.color2); end
        bus.vblnk_in = 1'b0;
        @(negedge pclk);
        checks++; if ({bus.done, bus.busy, bus.ypos, bus.color2} !== {2'b00, 12'd600, 12'hFFF}) begin errors++; $display("FAIL done_idle got done=%b busy=%b ypos=%0d c2=%h exp 0/0/600/FFF", bus.done, bus.busy, bus.ypos, bus.color2); end
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL done_count got %0d exp %0d", done_cnt, base + 1); end
    endtask

    task automatic test_abort();
        int base;
        base = done_cnt;
        pulse_start();
        for (int k = 0; k < 100; k++) do_tick(1);
        checks++; if (bus.ypos !== 12'd400) begin errors++; $display("FAIL abort_pre got %0d exp 400", bus.ypos); end
        @(negedge pclk) bus.abort = 1'b1;
        @(negedge pclk);
        checks++; if ({bus.ypos, bus.color2, bus.busy, bus.done} !== {12'd600, 12'hFFF, 2'b00}) begin errors++; $display("FAIL abort got ypos=%0d c2=%h busy=%b done=%b exp 600/FFF/0/0", bus.ypos, bus.color2, bus.busy, bus.done); end
        bus.abort = 1'b0;
        do_tick(1);
        checks++; if ({bus.ypos, bus.busy} !== {12'd600, 1'b0}) begin errors++; $display("FAIL abort_idle got ypos=%0d busy=%b exp 600/0", bus.ypos, bus.busy); end
        checks++; if (done_cnt !== base) begin errors++; $display("FAIL abort_done got %0d exp %0d", done_cnt, base); end
    endtask

    task automatic test_pause();
        pulse_start();
        for (int k = 0; k < 158; k++) do_tick(1);
        for (int k = 0; k < 100; k++) do_tick(1);
        bus.pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            do_tick(1);
            checks++; if ({bus.ypos, bus.color2, bus.busy} !== {12'd284, 12'hFFF, 1'b1}) begin errors++; $display("FAIL pause_hold tick %0d got ypos=%0d c2=%h busy=%b", k, bus.ypos, bus.color2, bus.busy); end
        end
        bus.pause = 1'b0;
        for (int k = 0; k < 23; k++) do_tick(1);
        checks++; if (bus.color2 !== 12'hFFF) begin errors++; $display("FAIL pause_hold_len got c2=%h exp FFF", bus.color2); end
        do_tick(1);
        checks++; if (bus.color2 !== 12'hEEE) begin errors++; $display("FAIL pause_fade_start got c2=%h exp EEE", bus.color2); end
        bus.pause = 1'b1;
        for (int k = 0; k < 8; k++) do_tick(1);
        checks++; if ({bus.color2, bus.busy} !== {12'hEEE, 1'b1}) begin errors++; $display("FAIL pause_fade got c2=%h busy=%b exp EEE/1", bus.color2, bus.busy); end
        @(negedge pclk) bus.abort = 1'b1;
        @(negedge pclk);
        checks++; if ({bus.busy, bus.color2} !== {1'b0, 12'hFFF}) begin errors++; $display("FAIL pause_abort got busy=%b c2=%h exp 0/FFF", bus.busy, bus.color2); end
        bus.abort = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic test_handshake();
        int base;
        base = done_cnt;
        pulse_start();
        for (int k = 0; k < 278; k++) do_tick(1);
        for (int k = 0; k < 8; k++) do_tick(1);
        checks++; if (bus.color2 !== 12'hDDD) begin errors++; $display("FAIL hs_fade got c2=%h exp DDD", bus.color2); end
        pulse_start();
        checks++; if ({bus.busy, bus.color2} !== {1'b1, 12'hDDD}) begin errors++; $display("FAIL hs_start_ignored got busy=%b c2=%h exp 1/DDD", bus.busy, bus.color2); end
        for (int k = 0; k < 51; k++) do_tick(1);
        @(negedge pclk) bus.vblnk_in = 1'b1;
        @(negedge pclk);
        checks++; if ({bus.done, bus.color2} !== {1'b1, 12'h000}) begin errors++; $display("FAIL hs_done got done=%b c2=%h exp 1/000", bus.done, bus.color2); end
        bus.vblnk_in = 1'b0;
        for (int k = 0; k < 3; k++) do_tick(1);
        checks++; if ({bus.busy, bus.ypos} !== {1'b0, 12'd600}) begin errors++; $display("FAIL hs_not_queued got busy=%b ypos=%0d exp 0/600", bus.busy, bus.ypos); end
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL hs_done_count got %0d exp %0d", done_cnt, base + 1); end
        @(negedge pclk) begin bus.start = 1'b1; bus.abort = 1'b1; end
        @(negedge pclk) begin bus.start = 1'b0; bus.abort = 1'b0; end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hs_start_abort got busy=%b exp 0", bus.busy); end
        do_tick(1);
        checks++; if ({bus.busy, bus.ypos} !== {1'b0, 12'd600}) begin errors++; $display("FAIL hs_start_abort_idle got busy=%b ypos=%0d exp 0/600", bus.busy, bus.ypos); end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_hold_fade();
        test_abort();
        test_pause();
        test_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
